// File: rtl/alu_wide_seq_pkg.sv
// +----------------------------------------------------------------------+
// | Module  : alu_wide_seq_pkg                                           |
// | Brief   : Shared opcode defines and FSM state type for alu_wide_seq. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package alu_wide_seq_pkg;

    localparam logic [2:0] ADD_FN  = 3'd0;
    localparam logic [2:0] ADDC_FN = 3'd1;
    localparam logic [2:0] SUB_FN  = 3'd2;
    localparam logic [2:0] SUBC_FN = 3'd3;
    localparam logic [2:0] AND_FN  = 3'd4;
    localparam logic [2:0] OR_FN   = 3'd5;
    localparam logic [2:0] XOR_FN  = 3'd6;
    localparam logic [2:0] MASK_FN = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } state_t;

    // Arithmetic ops are the only ones that produce a meaningful carry.
    function automatic logic is_arith(input logic [2:0] op);
        return (op == ADD_FN) || (op == ADDC_FN) || (op == SUB_FN) || (op == SUBC_FN);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_wide_seq.sv
// +----------------------------------------------------------------------+
// | Module  : alu_wide_seq                                               |
// | Brief   : Sequences a 16-bit op over an external 8-bit ALU, LO byte  |
// |           then HI byte, chaining carry/borrow between the halves.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module alu_wide_seq
    import alu_wide_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        zero_flag,
    output logic        carry_flag,
    output logic [7:0]  alu_in1,
    output logic [7:0]  alu_in2,
    output logic        cin,
    output logic [2:0]  opcode,
    input  logic [7:0]  alu_out,
    input  logic        alu_zero,
    input  logic        alu_cout
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_op;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [7:0]  r_lo_byte;
    logic        r_lo_carry;
    logic [15:0] r_result;
    logic        r_zero;
    logic        r_carry;
    logic        r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        alu_in1     = 8'h00;
        alu_in2     = 8'h00;
        cin         = 1'b0;
        opcode      = ADD_FN;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = LO;
                end
            end
            LO: begin
                w_state_nxt = HI;
                alu_in1     = r_a[7:0];
                alu_in2     = r_b[7:0];
                opcode      = r_op;
                // Carry-in variants chain from the previous 16-bit result.
                if ((r_op == ADDC_FN) || (r_op == SUBC_FN)) begin
                    cin = r_carry;
                end
            end
            HI: begin
                w_state_nxt = IDLE;
                alu_in1     = r_a[15:8];
                alu_in2     = r_b[15:8];
                opcode      = r_op;
                if ((r_op == ADD_FN) || (r_op == ADDC_FN)) begin
                    opcode = ADDC_FN;
                    cin    = r_lo_carry;
                end else if ((r_op == SUB_FN) || (r_op == SUBC_FN)) begin
                    opcode = SUBC_FN;
                    cin    = r_lo_carry;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op       <= ADD_FN;
            r_a        <= 16'h0000;
            r_b        <= 16'h0000;
            r_lo_byte  <= 8'h00;
            r_lo_carry <= 1'b0;
            r_result   <= 16'h0000;
            r_zero     <= 1'b0;
            r_carry    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if ((r_state == IDLE) && start) begin
                r_op <= op;
                r_a  <= a;
                r_b  <= b;
            end
            if (r_state == LO) begin
                r_lo_byte  <= alu_out;
                r_lo_carry <= alu_cout;
            end
            if (r_state == HI) begin
                r_result <= {alu_out, r_lo_byte};
                r_zero   <= alu_zero && (r_lo_byte == 8'h00);
                if (is_arith(r_op)) begin
                    r_carry <= alu_cout;
                end
                r_done <= 1'b1;
            end
        end
    end

    assign busy       = (r_state != IDLE);
    assign done       = r_done;
    assign result     = r_result;
    assign zero_flag  = r_zero;
    assign carry_flag = r_carry;

endmodule

`default_nettype wire

// File: tb/tb_alu_wide_seq.sv
// +----------------------------------------------------------------------+
// | Module  : tb_alu_wide_seq                                            |
// | Brief   : Directed bench for alu_wide_seq with a behavioural 8-bit   |
// |           ALU beside it. Revision: 1.0                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_alu_wide_seq;
    import alu_wide_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        zero_flag;
    logic        carry_flag;
    logic [7:0]  alu_in1;
    logic [7:0]  alu_in2;
    logic        cin;
    logic [2:0]  opcode;
    logic [7:0]  alu_out;
    logic        alu_zero;
    logic        alu_cout;

    int checks = 0;
    int errors = 0;

    alu_wide_seq dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .zero_flag  (zero_flag),
        .carry_flag (carry_flag),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .cin        (cin),
        .opcode     (opcode),
        .alu_out    (alu_out),
        .alu_zero   (alu_zero),
        .alu_cout   (alu_cout)
    );

    always #5 clk = ~clk;

    // 8-bit ALU; carry out on subtract is a borrow.
    logic [8:0] w_tmp;
    always_comb begin
        w_tmp = 9'h000;
        case (opcode)
            ADD_FN:  w_tmp = {1'b0, alu_in1} + {1'b0, alu_in2};
            ADDC_FN: w_tmp = {1'b0, alu_in1} + {1'b0, alu_in2} + {8'h00, cin};
            SUB_FN:  w_tmp = {1'b0, alu_in1} - {1'b0, alu_in2};
            SUBC_FN: w_tmp = {1'b0, alu_in1} - {1'b0, alu_in2} - {8'h00, cin};
            AND_FN:  w_tmp = {1'b0, alu_in1 & alu_in2};
            OR_FN:   w_tmp = {1'b0, alu_in1 | alu_in2};
            XOR_FN:  w_tmp = {1'b0, alu_in1 ^ alu_in2};
            MASK_FN: w_tmp = {1'b0, alu_in1 & ~alu_in2};
            default: w_tmp = 9'h000;
        endcase
    end
    assign alu_out  = w_tmp[7:0];
    assign alu_cout = w_tmp[8];
    assign alu_zero = (w_tmp[7:0] == 8'h00);

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        zero;
        logic        carry;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Issues one op and checks busy/done timing plus the final result/flags.
    task automatic run_op(input string tag, input vec_t v);
        @(negedge clk);
        start = 1'b1;
        op    = v.op;
        a     = v.a;
        b     = v.b;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, " busy LO"}, {15'd0, busy}, 16'd1);
        chk({tag, " done LO"}, {15'd0, done}, 16'd0);
        @(posedge clk);
        #1;
        chk({tag, " busy HI"}, {15'd0, busy}, 16'd1);
        @(posedge clk);
        #1;
        chk({tag, " done"}, {15'd0, done}, 16'd1);
        chk({tag, " busy idle"}, {15'd0, busy}, 16'd0);
        chk({tag, " result"}, result, v.res);
        chk({tag, " zero"}, {15'd0, zero_flag}, {15'd0, v.zero});
        chk({tag, " carry"}, {15'd0, carry_flag}, {15'd0, v.carry});
    endtask

    initial begin
        int   n_done;
        vec_t v;

        vecs[0]  = '{ADD_FN,  16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0};
        vecs[1]  = '{ADD_FN,  16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1};
        vecs[2]  = '{ADDC_FN, 16'h0001, 16'h0001, 16'h0003, 1'b0, 1'b0};
        vecs[3]  = '{SUB_FN,  16'h0100, 16'h0001, 16'h00FF, 1'b0, 1'b0};
        vecs[4]  = '{SUB_FN,  16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b1};
        vecs[5]  = '{XOR_FN,  16'hA5A5, 16'hA5A5, 16'h0000, 1'b1, 1'b1};
        vecs[6]  = '{MASK_FN, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b1};
        vecs[7]  = '{AND_FN,  16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b1};
        vecs[8]  = '{OR_FN,   16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b1};
        vecs[9]  = '{SUBC_FN, 16'h0005, 16'h0003, 16'h0001, 1'b0, 1'b0};
        vecs[10] = '{SUBC_FN, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0};
        vecs[11] = '{ADD_FN,  16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0};
        vecs[12] = '{ADD_FN,  16'h0100, 16'hFF00, 16'h0000, 1'b1, 1'b1};
        vecs[13] = '{MASK_FN, 16'hF00F, 16'h0F0F, 16'hF000, 1'b0, 1'b1};
        vecs[14] = '{ADDC_FN, 16'h00FE, 16'h0001, 16'h0100, 1'b0, 1'b0};
        vecs[15] = '{SUB_FN,  16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b0};

        rst   = 1'b1;
        start = 1'b0;
        op    = ADD_FN;
        a     = 16'h0000;
        b     = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", {15'd0, busy}, 16'd0);
        chk("reset done", {15'd0, done}, 16'd0);
        chk("reset result", result, 16'h0000);
        chk("reset flags", {14'd0, zero_flag, carry_flag}, 16'd0);
        chk("reset idle opcode", {13'd0, opcode}, {13'd0, ADD_FN});
        chk("reset idle operands", {alu_in1, alu_in2}, 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back: each op is issued in the done cycle of the previous one.
        for (int i = 0; i < 16; i++) begin
            run_op($sformatf("v%0d", i), vecs[i]);
        end

        // start during LO is dropped; exactly one completion.
        @(negedge clk);
        start = 1'b1;
        op    = ADD_FN;
        a     = 16'h0001;
        b     = 16'h0001;
        @(posedge clk);
        #1;
        op    = SUB_FN;
        a     = 16'h0000;
        b     = 16'h0009;
        n_done = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) n_done++;
        end
        chk("ignored start done count", n_done[15:0], 16'd1);
        chk("ignored start result", result, 16'h0002);
        chk("ignored start busy", {15'd0, busy}, 16'd0);

        // Reset during HI aborts: no done, everything cleared.
        v = '{ADD_FN, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1};
        run_op("pre-abort", v);
        @(negedge clk);
        start = 1'b1;
        op    = ADD_FN;
        a     = 16'h1111;
        b     = 16'h2222;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("abort in HI busy", {15'd0, busy}, 16'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort busy", {15'd0, busy}, 16'd0);
        chk("abort done", {15'd0, done}, 16'd0);
        chk("abort result", result, 16'h0000);
        chk("abort flags", {14'd0, zero_flag, carry_flag}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        chk("abort no done pulse", n_done[15:0], 16'd0);

        // Reset wins over start.
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("rst priority busy", {15'd0, busy}, 16'd0);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("rst priority still idle", {15'd0, busy}, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
